ddr3_user_port_arbiter: RTL and testbench

DDR3_USER_PORT_ARBITER -- requirements
Module: ddr3_user_port_arbiter

---
 rtl/ddr3_arb_pkg.sv | 15 +
 rtl/ddr3_rr_grant.sv | 18 +
 rtl/ddr3_user_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ddr3_user_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared constants and FSM encoding for the two-port DDR3 user-port arbiter.
package ddr3_arb_pkg;

  localparam int unsigned DefAddrW         = 18;
  localparam int unsigned DefDqW           = 16;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/ddr3_rr_grant.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the port not granted last.
module ddr3_rr_grant (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    if (&valid) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/ddr3_user_port_arbiter.sv
// Two user ports sharing one DDR3 controller, one command outstanding at a time.
// Optional completion watchdog enabled by defining DDR3_ARB_TIMEOUT_EN.
module ddr3_user_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DQ_W           = DefDqW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DQ_W-1:0]   p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DQ_W-1:0]   p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DQ_W-1:0]   p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DQ_W-1:0]   p1_rsp_rdata,
  output logic              p1_rsp_err,
  input  logic              ctrl_ready,
  output logic              ctrl_write_enable,
  output logic              ctrl_read_enable,
  output logic [ADDR_W-1:0] ctrl_address,
  output logic [DQ_W-1:0]   ctrl_wdata,
  input  logic              ctrl_rdata_valid,
  input  logic [DQ_W-1:0]   ctrl_rdata
);

  arb_state_e        state_q, state_d;
  logic              port_q, we_q, last_grant_q, first_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DQ_W-1:0]   wdata_q, rdata_q;
  logic              wr_en_q, rd_en_q;
  logic              grant, grant_valid;
  logic              in_idle, accept, issue, wait_done, timeout_hit, rsp;

  ddr3_rr_grant u_grant (
    .valid      ({p1_req_valid, p0_req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  assign in_idle = (state_q == StIdle) && !reset;
  assign accept  = in_idle && grant_valid;
  assign issue   = (state_q == StIssue) && ctrl_ready;
  // The first WAIT cycle overlaps the enable pulse, so controller status is not yet meaningful.
  assign wait_done = (state_q == StWait) && !first_q && (we_q ? ctrl_ready : ctrl_rdata_valid);
  assign rsp       = (state_q == StResp);

  assign p0_req_ready      = accept && !grant;
  assign p1_req_ready      = accept && grant;
  assign p0_rsp_valid      = rsp && !port_q;
  assign p1_rsp_valid      = rsp && port_q;
  assign p0_rsp_rdata      = rdata_q;
  assign p1_rsp_rdata      = rdata_q;
  assign ctrl_write_enable = wr_en_q;
  assign ctrl_read_enable  = rd_en_q;
  assign ctrl_address      = addr_q;
  assign ctrl_wdata        = wdata_q;

`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == StWait) && !wait_done &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign p0_rsp_err  = p0_rsp_valid && err_q;
  assign p1_rsp_err  = p1_rsp_valid && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (issue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign p0_rsp_err     = 1'b0;
  assign p1_rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (issue) state_d = StWait;
      StWait:  if (wait_done || timeout_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= issue && we_q;
      rd_en_q <= issue && !we_q;
      first_q <= issue;
      if (accept) begin
        port_q       <= grant;
        last_grant_q <= grant;
        we_q         <= grant ? p1_req_we : p0_req_we;
        addr_q       <= grant ? p1_req_addr : p0_req_addr;
        wdata_q      <= grant ? p1_req_wdata : p0_req_wdata;
        rdata_q      <= '0;
      end else if (wait_done && !we_q) begin
        rdata_q <= ctrl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Self-checking bench: directed scenarios plus random two-port traffic against a transaction model.
module tb_ddr3_user_port_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int unsigned TbTimeout = 16;
`else
  localparam int unsigned TbTimeout = 1024;
`endif

  logic          clk, reset;
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_err;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_err;
  logic [AW-1:0] p0_req_addr, p1_req_addr, ctrl_address;
  logic [DW-1:0] p0_req_wdata, p1_req_wdata, p0_rsp_rdata, p1_rsp_rdata;
  logic          ctrl_ready, ctrl_write_enable, ctrl_read_enable, ctrl_rdata_valid;
  logic [DW-1:0] ctrl_wdata, ctrl_rdata;
  logic [73:0]   all_outs;

  ddr3_user_port_arbiter #(
    .ADDR_W        (AW),
    .DQ_W          (DW),
    .TIMEOUT_CYCLES(TbTimeout)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .p0_req_valid     (p0_req_valid),
    .p0_req_ready     (p0_req_ready),
    .p0_req_we        (p0_req_we),
    .p0_req_addr      (p0_req_addr),
    .p0_req_wdata     (p0_req_wdata),
    .p0_rsp_valid     (p0_rsp_valid),
    .p0_rsp_rdata     (p0_rsp_rdata),
    .p0_rsp_err       (p0_rsp_err),
    .p1_req_valid     (p1_req_valid),
    .p1_req_ready     (p1_req_ready),
    .p1_req_we        (p1_req_we),
    .p1_req_addr      (p1_req_addr),
    .p1_req_wdata     (p1_req_wdata),
    .p1_rsp_valid     (p1_rsp_valid),
    .p1_rsp_rdata     (p1_rsp_rdata),
    .p1_rsp_err       (p1_rsp_err),
    .ctrl_ready       (ctrl_ready),
    .ctrl_write_enable(ctrl_write_enable),
    .ctrl_read_enable (ctrl_read_enable),
    .ctrl_address     (ctrl_address),
    .ctrl_wdata       (ctrl_wdata),
    .ctrl_rdata_valid (ctrl_rdata_valid),
    .ctrl_rdata       (ctrl_rdata)
  );

  assign all_outs = {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err,
                     p1_rsp_err, ctrl_write_enable, ctrl_read_enable, ctrl_address, ctrl_wdata,
                     p0_rsp_rdata, p1_rsp_rdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  int n_pass, n_checks, cyc;
  // Transaction model: one command in flight, round-robin on ties.
  logic m_last;
  bit   m_busy, m_en_seen, exp_err;
  cmd_t m_cmd;
  // Controller model.
  bit            rd_never, rd_rand, ready_rand, rd_pend;
  int            rd_cnt;
  logic [DW-1:0] rd_val, rd_data_cfg, last_rd, rsp_rdata;
  // Observations.
  int wr_pulses, rd_pulses, p0_rsps, p1_rsps, acc_cyc, en_cyc, rsp_cyc, rv_cyc;
  int acc_q[$];
  int lat_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy    = 0;
    m_en_seen = 0;
    m_last    = 1'b1;
    rd_pend   = 0;
    exp_err   = 0;
  endtask

  task automatic tick();
    bit pv0, pv1, acc0, acc1, wen, ren, r0, r1;
    @(negedge clk);
    pv0  = p0_req_valid;
    pv1  = p1_req_valid;
    acc0 = pv0 && p0_req_ready;
    acc1 = pv1 && p1_req_ready;
    wen  = ctrl_write_enable;
    ren  = ctrl_read_enable;
    r0   = p0_rsp_valid;
    r1   = p1_rsp_valid;
    if (!reset) begin
      if (acc0 || acc1) begin
        chk("single_accept", acc0 && acc1, 0);
        chk("accept_while_idle", m_busy, 0);
        chk("grant_port", acc1, (pv0 && pv1) ? !m_last : pv1);
        m_cmd.port  = acc1;
        m_cmd.we    = acc1 ? p1_req_we : p0_req_we;
        m_cmd.addr  = acc1 ? p1_req_addr : p0_req_addr;
        m_cmd.wdata = acc1 ? p1_req_wdata : p0_req_wdata;
        m_last      = acc1;
        m_busy      = 1;
        m_en_seen   = 0;
        acc_cyc     = cyc;
        acc_q.push_back(int'(acc1));
      end
      if (wen || ren) begin
        wr_pulses += int'(wen);
        rd_pulses += int'(ren);
        chk("enable_exclusive", wen && ren, 0);
        chk("enable_once", m_busy && !m_en_seen, 1);
        chk("enable_kind", wen, m_cmd.we);
        chk("enable_addr", ctrl_address, m_cmd.addr);
        chk("enable_wdata", ctrl_wdata, m_cmd.wdata);
        chk("enable_latency_min", (cyc - acc_cyc) >= 2, 1);
        m_en_seen = 1;
        en_cyc    = cyc;
        lat_q.push_back(cyc - acc_cyc);
      end
      if (r0 || r1) begin
        p0_rsps += int'(r0);
        p1_rsps += int'(r1);
        chk("rsp_single", r0 && r1, 0);
        chk("rsp_owner", r1, m_cmd.port);
        chk("rsp_after_enable", m_busy && m_en_seen, 1);
        rsp_rdata = r1 ? p1_rsp_rdata : p0_rsp_rdata;
        chk("rsp_rdata", rsp_rdata, (m_cmd.we || exp_err) ? 16'h0 : last_rd);
        chk("rsp_err", r1 ? p1_rsp_err : p0_rsp_err, exp_err);
        m_busy  = 0;
        rsp_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc0) p0_req_valid = 1'b0;
    if (acc1) p1_req_valid = 1'b0;
    ctrl_rdata_valid = 1'b0;
    if (ready_rand) ctrl_ready = ($urandom_range(0, 3) != 0);
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata       = rd_val;
        last_rd          = rd_val;
        rd_pend          = 0;
        rv_cyc           = cyc;
      end else begin
        rd_cnt--;
      end
    end
    if (ren && !rd_never && !reset) begin
      rd_pend = 1;
      rd_cnt  = rd_rand ? int'($urandom_range(0, 3)) : 0;
      rd_val  = rd_rand ? DW'($urandom) : rd_data_cfg;
    end
  endtask

  task automatic drain(input int limit, input string tag);
    int n = 0;
    while ((m_busy || p0_req_valid || p1_req_valid) && n < limit) begin
      tick();
      n++;
    end
    chk(tag, m_busy || p0_req_valid || p1_req_valid, 0);
  endtask

  task automatic req(input bit port, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata);
    if (port) begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
    end else begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, base;
    n_pass = 0; n_checks = 0; cyc = 0;
    wr_pulses = 0; rd_pulses = 0; p0_rsps = 0; p1_rsps = 0;
    acc_cyc = 0; en_cyc = 0; rsp_cyc = 0; rv_cyc = 0;
    rd_never = 0; rd_rand = 0; ready_rand = 0; rd_cnt = 0;
    rd_val = '0; rd_data_cfg = '0; last_rd = '0; rsp_rdata = '0;
    m_cmd = '{port: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    model_reset();
    reset = 1'b1;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = '0; p1_req_wdata = '0;
    ctrl_ready = 0; ctrl_rdata_valid = 0; ctrl_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_outputs", all_outs, 0);

    // Tie after reset: port0 first, then port1, two single-cycle write pulses.
    ctrl_ready = 1'b1;
    acc_q.delete(); lat_q.delete();
    req(0, 1, 18'h12345, 16'hA5A5);
    req(1, 1, 18'h0ABCD, 16'h5A5A);
    drain(100, "pair_drain");
    chk("pair_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("pair_first_port0", acc_q[0], 0);
      chk("pair_second_port1", acc_q[1], 1);
      chk("accept_to_enable_latency", lat_q[0], 2);
    end
    chk("pair_wr_pulses", wr_pulses, 2);
    chk("pair_rd_pulses", rd_pulses, 0);

    // Port1 read returning 0xBEEF.
    b0 = p0_rsps; b1 = p1_rsps; base = rd_pulses;
    rd_data_cfg = 16'hBEEF;
    req(1, 0, 18'h00005, 16'h0);
    drain(100, "read_drain");
    chk("read_p1_rsp_count", p1_rsps - b1, 1);
    chk("read_p0_rsp_count", p0_rsps - b0, 0);
    chk("read_rdata", rsp_rdata, 16'hBEEF);
    chk("read_rsp_latency", rsp_cyc - rv_cyc, 1);
    chk("read_rd_pulses", rd_pulses - base, 1);

    // Controller busy for 50+ cycles while a write sits in ISSUE.
    ctrl_ready = 1'b0;
    base = wr_pulses;
    req(0, 1, 18'h2AAAA, 16'h1357);
    repeat (52) tick();
    chk("stall_no_pulse", wr_pulses - base, 0);
    chk("stall_holding", m_busy, 1);
    ctrl_ready = 1'b1;
    drain(100, "stall_drain");
    chk("stall_one_pulse", wr_pulses - base, 1);

    // Reset while waiting for read data; stray read data afterwards.
    rd_never = 1;
    req(0, 0, 18'h3FFFF, 16'h0);
    for (int i = 0; i < 20 && !m_en_seen; i++) tick();
    chk("abort_reached_wait", m_en_seen, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    rd_never = 0;
    b0 = p0_rsps; b1 = p1_rsps;
    chk("abort_outputs", all_outs, 0);
    ctrl_rdata_valid = 1'b1;
    ctrl_rdata = 16'h1234;
    repeat (4) tick();
    chk("abort_no_rsp", (p0_rsps - b0) + (p1_rsps - b1), 0);
    chk("stray_rdata_ignored", all_outs, 0);
    acc_q.delete();
    rd_data_cfg = 16'h1111;
    req(0, 0, 18'h00010, 16'h0);
    req(1, 0, 18'h00020, 16'h0);
    drain(100, "abort_tie_drain");
    if (acc_q.size() > 0) chk("abort_tie_port0", acc_q[0], 0);
    else chk("abort_tie_accepts", acc_q.size(), 2);

    // Random two-port traffic with a jittery controller.
    ready_rand = 1; rd_rand = 1;
    base = p0_rsps + p1_rsps;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!p0_req_valid && $urandom_range(0, 1) == 1)
        req(0, 1'($urandom), AW'($urandom), DW'($urandom));
      if (!p1_req_valid && $urandom_range(0, 1) == 1)
        req(1, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    drain(300, "random_drain");
    chk("random_traffic", (p0_rsps + p1_rsps - base) > 20, 1);
    ready_rand = 0; rd_rand = 0;
    ctrl_ready = 1'b1;

`ifdef DDR3_ARB_TIMEOUT_EN
    // Read data never returns: error response after 16 WAIT cycles.
    rd_never = 1; exp_err = 1;
    b1 = p1_rsps;
    req(1, 0, 18'h00007, 16'h0);
    drain(100, "timeout_drain");
    chk("timeout_rsp_count", p1_rsps - b1, 1);
    chk("timeout_wait_cycles", rsp_cyc - en_cyc, 16);
    rd_never = 0; exp_err = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
